// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent toggle flip-flops with synchronous load and per-bit toggle strobe.
// Optional bit-0 toggle-event counter is compiled in when T_FF_TOGGLE_CNT_EN is defined.

module t_ff_lane #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic load,
    input  logic d,
    output logic q,
    output logic toggled
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RST_VAL;
            toggled <= 1'b0;
        end else if (load) begin
            q       <= d;
            toggled <= 1'b0;
        end else begin
            q       <= q ^ t;
            toggled <= t;
        end
    end

endmodule

module t_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
`ifdef T_FF_TOGGLE_CNT_EN
    output logic [CNT_W-1:0] toggle_cnt,
`endif
    output logic [WIDTH-1:0] toggled
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("t_flip_flop: WIDTH %0d outside 1..64", WIDTH);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("t_flip_flop: CNT_W %0d outside 1..32", CNT_W);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        t_ff_lane #(
            .RST_VAL (RESET_VAL[i])
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .t       (t[i]),
            .load    (load),
            .d       (d[i]),
            .q       (q[i]),
            .toggled (toggled[i])
        );
    end

    // Complement is derived, not stored, so q and qbar can never disagree.
    assign qbar = ~q;

`ifdef T_FF_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_r <= '0;
        else if (!load && t[0])
            cnt_r <= cnt_r + CNT_W'(1);
    end

    assign toggle_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: WIDTH=1 hold/toggle/reset, WIDTH=4 load priority and counter.

module tb_t_flip_flop;

    logic       clk;
    logic       rst_n;
    logic       t1, load1, d1;
    logic       q1, qbar1, tog1;
    logic [3:0] t4, d4, q4, qbar4, tog4;
    logic       load4;
`ifdef T_FF_TOGGLE_CNT_EN
    logic [15:0] cnt1;
    logic [1:0]  cnt4;
    logic [1:0]  exp_cnt;
`endif
    logic [3:0] exp_q4;

    int total = 0;
    int bad   = 0;

    t_flip_flop #(.WIDTH(1)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .t          (t1),
        .load       (load1),
        .d          (d1),
        .q          (q1),
        .qbar       (qbar1),
`ifdef T_FF_TOGGLE_CNT_EN
        .toggle_cnt (cnt1),
`endif
        .toggled    (tog1)
    );

    t_flip_flop #(.WIDTH(4), .CNT_W(2)) u4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .t          (t4),
        .load       (load4),
        .d          (d4),
        .q          (q4),
        .qbar       (qbar4),
`ifdef T_FF_TOGGLE_CNT_EN
        .toggle_cnt (cnt4),
`endif
        .toggled    (tog4)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; t1 = 1'b0; load1 = 1'b0; d1 = 1'b0;
        t4 = 4'h0; load4 = 1'b0; d4 = 4'h0;

        // asynchronous reset before the first clock edge
        #5 rst_n = 1'b0;
        #1;
        chk("rst_q1", q1, 1'b0);
        chk("rst_qbar1", qbar1, 1'b1);
        chk("rst_tog1", tog1, 1'b0);
        chk("rst_q4", q4, 4'h0);
        chk("rst_qbar4", qbar4, 4'hf);
`ifdef T_FF_TOGGLE_CNT_EN
        chk("rst_cnt4", cnt4, 2'd0);
`endif

        @(negedge clk) rst_n = 1'b1;

        // hold with t=0
        for (int k = 0; k < 2; k++) begin
            edge_sample();
            chk("hold_q1", q1, 1'b0);
            chk("hold_qbar1", qbar1, 1'b1);
            chk("hold_tog1", tog1, 1'b0);
        end

        // toggle with t=1 for two edges
        @(negedge clk) t1 = 1'b1;
        edge_sample();
        chk("tgl1_q1", q1, 1'b1);
        chk("tgl1_qbar1", qbar1, 1'b0);
        chk("tgl1_tog1", tog1, 1'b1);
        edge_sample();
        chk("tgl2_q1", q1, 1'b0);
        chk("tgl2_qbar1", qbar1, 1'b1);
        chk("tgl2_tog1", tog1, 1'b1);
        @(negedge clk) t1 = 1'b0;
        edge_sample();
        chk("tgl3_q1", q1, 1'b0);
        chk("tgl3_tog1", tog1, 1'b0);

        // bit-0 toggling on the 4-bit bank, with counter wrap at CNT_W=2
        exp_q4 = 4'h0;
`ifdef T_FF_TOGGLE_CNT_EN
        exp_cnt = 2'd0;
`endif
        @(negedge clk) t4 = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            edge_sample();
            exp_q4 = exp_q4 ^ 4'b0001;
            chk("cnt_q4", q4, exp_q4);
            chk("cnt_tog4", tog4, 4'b0001);
`ifdef T_FF_TOGGLE_CNT_EN
            exp_cnt = exp_cnt + 2'd1;
            chk("cnt_val", cnt4, exp_cnt);
`endif
        end

        // a t pulse that does not span a rising edge is ignored
        @(negedge clk) t4 = 4'h0;
        #3 t4 = 4'hf;
        #3 t4 = 4'h0;
        edge_sample();
        chk("glitch_q4", q4, 4'b0001);
        chk("glitch_tog4", tog4, 4'h0);

        // load beats t
        @(negedge clk) begin load4 = 1'b1; d4 = 4'b1010; t4 = 4'b1111; end
        edge_sample();
        chk("load_q4", q4, 4'b1010);
        chk("load_qbar4", qbar4, 4'b0101);
        chk("load_tog4", tog4, 4'h0);
`ifdef T_FF_TOGGLE_CNT_EN
        chk("load_cnt", cnt4, 2'd1);
`endif
        @(negedge clk) begin load4 = 1'b0; t4 = 4'b0011; end
        edge_sample();
        chk("post_load_q4", q4, 4'b1001);
        chk("post_load_tog4", tog4, 4'b0011);
`ifdef T_FF_TOGGLE_CNT_EN
        chk("post_load_cnt", cnt4, 2'd2);
`endif
        @(negedge clk) t4 = 4'h0;

        // reset in the middle of a toggle run
        t1 = 1'b1;
        edge_sample();
        chk("mid_pre_q1", q1, 1'b1);
        #4 rst_n = 1'b0;
        #1;
        chk("mid_rst_q1", q1, 1'b0);
        chk("mid_rst_qbar1", qbar1, 1'b1);
        chk("mid_rst_tog1", tog1, 1'b0);
        chk("mid_rst_q4", q4, 4'h0);
`ifdef T_FF_TOGGLE_CNT_EN
        chk("mid_rst_cnt4", cnt4, 2'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        edge_sample();
        chk("resume1_q1", q1, 1'b1);
        chk("resume1_tog1", tog1, 1'b1);
        edge_sample();
        chk("resume2_q1", q1, 1'b0);
        chk("resume2_qbar1", qbar1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
